// File: rtl/gba_sound_pkg.sv
// Shared types and constants for the GBA PSG mixer path.
package gba_sound_pkg;

  localparam int unsigned PSG_NUM_CH = 4;
  localparam int unsigned PSG_IDX_W  = 2;
  localparam int unsigned PSG_VOL_W  = 3;

  // SOUNDCNT_H PSG volume ratio; the reserved code behaves as full scale.
  typedef enum logic [1:0] {
    RATIO_25   = 2'd0,
    RATIO_50   = 2'd1,
    RATIO_100  = 2'd2,
    RATIO_RSVD = 2'd3
  } psg_ratio_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } psg_mix_state_t;

  // Register snapshot taken at the sample tick and held for the whole mix.
  typedef struct packed {
    logic [PSG_NUM_CH-1:0] ch_on;
    logic [PSG_NUM_CH-1:0] enable_l;
    logic [PSG_NUM_CH-1:0] enable_r;
    logic [PSG_VOL_W-1:0]  vol_l;
    logic [PSG_VOL_W-1:0]  vol_r;
    psg_ratio_t            ratio;
  } psg_mix_cfg_t;

endpackage

// File: rtl/gba_sound_psg_scale.sv
// Master volume multiply, PSG ratio shift and output width reduction.
// GBA_PSG_MIX_SATURATE_EN: clamp to the OUT_W signed range instead of wrapping.
module gba_sound_psg_scale
  import gba_sound_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W+1:0]    acc,
  input  logic [PSG_VOL_W-1:0]      vol,
  input  psg_ratio_t                ratio,
  output logic signed [OUT_W-1:0]   scaled_c
);

  localparam int unsigned ACC_W  = IN_W + 2;
  localparam int unsigned PROD_W = IN_W + 5;

`ifdef GBA_PSG_MIX_SATURATE_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));
`endif

  logic signed [PROD_W-1:0] acc_ext;
  logic signed [PROD_W-1:0] gain;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Scale by (vol+1), apply the ratio as an arithmetic shift, then fit to OUT_W.
  always_comb begin
    acc_ext = {{(PROD_W - ACC_W){acc[ACC_W-1]}}, acc};
    gain    = {{(PROD_W - PSG_VOL_W - 1){1'b0}},
               ({1'b0, vol} + (PSG_VOL_W + 1)'(1))};
    prod    = acc_ext * gain;
    shifted = prod;
    case (ratio)
      RATIO_25: shifted = prod >>> 2;
      RATIO_50: shifted = prod >>> 1;
      default:  shifted = prod;
    endcase
`ifdef GBA_PSG_MIX_SATURATE_EN
    if (shifted > SAT_MAX) begin
      scaled_c = OUT_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      scaled_c = OUT_W'(SAT_MIN);
    end else begin
      scaled_c = OUT_W'(shifted);
    end
`else
    scaled_c = OUT_W'(shifted);
`endif
  end

endmodule

// File: rtl/gba_sound_psg_mixer.sv
// Stereo mixer for the four legacy PSG channels: gate, sum, volume, ratio.
// GBA_PSG_MIX_SATURATE_EN: saturating output (see gba_sound_psg_scale).
module gba_sound_psg_mixer
  import gba_sound_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gb_on,
  input  logic                         sample_tick,
  input  logic [PSG_NUM_CH*IN_W-1:0]   ch_sample,
  input  logic [PSG_NUM_CH-1:0]        ch_on,
  input  logic [PSG_NUM_CH-1:0]        enable_l,
  input  logic [PSG_NUM_CH-1:0]        enable_r,
  input  logic [PSG_VOL_W-1:0]         vol_l,
  input  logic [PSG_VOL_W-1:0]         vol_r,
  input  logic [1:0]                   psg_ratio,
  output logic signed [OUT_W-1:0]      out_l,
  output logic signed [OUT_W-1:0]      out_r,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned ACC_W = IN_W + 2;

  psg_mix_state_t                     state_q, state_d;
  logic [PSG_IDX_W-1:0]               idx_q, idx_d;
  logic [PSG_NUM_CH-1:0][IN_W-1:0]    samp_q, samp_d;
  psg_mix_cfg_t                       cfg_q, cfg_d;
  logic signed [ACC_W-1:0]            acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]            acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0]            scl_l_q, scl_l_d;
  logic signed [OUT_W-1:0]            scl_r_q, scl_r_d;
  logic signed [OUT_W-1:0]            out_l_q, out_l_d;
  logic signed [OUT_W-1:0]            out_r_q, out_r_d;
  logic                               out_valid_q, out_valid_d;
  logic                               busy_q, busy_d;
  logic                               overrun_q, overrun_d;

  logic signed [IN_W-1:0]             cur_sample_c;
  logic signed [ACC_W-1:0]            cur_ext_c;
  logic signed [OUT_W-1:0]            scaled_l_c;
  logic signed [OUT_W-1:0]            scaled_r_c;

  gba_sound_psg_scale #(.IN_W(IN_W), .OUT_W(OUT_W)) u_scale_l (
    .acc      (acc_l_q),
    .vol      (cfg_q.vol_l),
    .ratio    (cfg_q.ratio),
    .scaled_c (scaled_l_c)
  );

  gba_sound_psg_scale #(.IN_W(IN_W), .OUT_W(OUT_W)) u_scale_r (
    .acc      (acc_r_q),
    .vol      (cfg_q.vol_r),
    .ratio    (cfg_q.ratio),
    .scaled_c (scaled_r_c)
  );

  // Sign-extended sample of the channel currently being accumulated.
  always_comb begin
    cur_sample_c = samp_q[idx_q];
    cur_ext_c    = {{(ACC_W - IN_W){cur_sample_c[IN_W-1]}}, cur_sample_c};
  end

  // Mix sequencing: snapshot on tick, accumulate per channel, scale, publish.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    samp_d      = samp_q;
    cfg_d       = cfg_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    scl_l_d     = scl_l_q;
    scl_r_d     = scl_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          samp_d         = ch_sample;
          cfg_d.ch_on    = ch_on;
          cfg_d.enable_l = enable_l;
          cfg_d.enable_r = enable_r;
          cfg_d.vol_l    = vol_l;
          cfg_d.vol_r    = vol_r;
          cfg_d.ratio    = psg_ratio_t'(psg_ratio);
          acc_l_d        = '0;
          acc_r_d        = '0;
          idx_d          = '0;
          busy_d         = 1'b1;
          state_d        = ACC;
        end
      end
      ACC: begin
        if (cfg_q.ch_on[idx_q] && cfg_q.enable_l[idx_q]) begin
          acc_l_d = acc_l_q + cur_ext_c;
        end
        if (cfg_q.ch_on[idx_q] && cfg_q.enable_r[idx_q]) begin
          acc_r_d = acc_r_q + cur_ext_c;
        end
        if (idx_q == PSG_IDX_W'(PSG_NUM_CH - 1)) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + PSG_IDX_W'(1);
        end
      end
      SCALE: begin
        scl_l_d = scaled_l_c;
        scl_r_d = scaled_r_c;
        state_d = OUT;
      end
      OUT: begin
        out_l_d     = scl_l_q;
        out_r_d     = scl_r_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A tick outside IDLE is dropped and remembered until reset.
    if (sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers; sound master disable acts as reset.
  always_ff @(posedge clk) begin
    if (reset || !gb_on) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      samp_q      <= '0;
      cfg_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      scl_l_q     <= '0;
      scl_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      samp_q      <= samp_d;
      cfg_q       <= cfg_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      scl_l_q     <= scl_l_d;
      scl_r_q     <= scl_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_gba_sound_psg_mixer.sv
// Self-checking bench for gba_sound_psg_mixer: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_gba_sound_psg_mixer;

  logic               clk = 1'b0;
  logic               reset;
  logic               gb_on;
  logic               sample_tick;
  logic signed [15:0] smp [4];
  logic [63:0]        ch_sample;
  logic [3:0]         ch_on;
  logic [3:0]         enable_l;
  logic [3:0]         enable_r;
  logic [2:0]         vol_l;
  logic [2:0]         vol_r;
  logic [1:0]         psg_ratio;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int n_total = 0;
  int n_bad   = 0;

  assign ch_sample = {smp[3], smp[2], smp[1], smp[0]};

  always #5 clk = ~clk;

  gba_sound_psg_mixer #(.IN_W(16), .OUT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .gb_on       (gb_on),
    .sample_tick (sample_tick),
    .ch_sample   (ch_sample),
    .ch_on       (ch_on),
    .enable_l    (enable_l),
    .enable_r    (enable_r),
    .vol_l       (vol_l),
    .vol_r       (vol_r),
    .psg_ratio   (psg_ratio),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected mix from current inputs: gated sum, times (vol+1), ratio, fit to 16 bits.
  function automatic logic signed [15:0] ref_mix(input logic [3:0] on, input logic [3:0] en,
                                                 input logic [2:0] vol, input logic [1:0] rt);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      if (on[i] && en[i]) s += int'(smp[i]);
    end
    s = s * (int'(vol) + 1);
    if (rt == 2'd0) s = s >>> 2;
    else if (rt == 2'd1) s = s >>> 1;
`ifdef GBA_PSG_MIX_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  // Behavioural model: a mix accepted at an edge appears 6 edges later.
  int                 m_cnt;
  bit                 m_seen = 1'b0;
  bit                 m_busy, m_valid, m_ovr, was_busy;
  logic signed [15:0] m_l, m_r, p_l, p_r;

  always @(posedge clk) begin
    if (reset || !gb_on) begin
      m_l = '0; m_r = '0; m_valid = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_cnt = 0;
      m_seen = 1'b1;
    end else begin
      was_busy = m_busy;
      m_valid  = 1'b0;
      if (was_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_l = p_l; m_r = p_r; m_valid = 1'b1; m_busy = 1'b0;
        end
      end
      if (sample_tick) begin
        if (was_busy) begin
          m_ovr = 1'b1;
        end else begin
          p_l    = ref_mix(ch_on, enable_l, vol_l, psg_ratio);
          p_r    = ref_mix(ch_on, enable_r, vol_r, psg_ratio);
          m_busy = 1'b1;
          m_cnt  = 6;
        end
      end
    end
    #1;
    if (m_seen) begin
      chk("model_out_l", int'(out_l), int'(m_l));
      chk("model_out_r", int'(out_r), int'(m_r));
      chk("model_out_valid", int'(out_valid), int'(m_valid));
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_overrun", int'(overrun), int'(m_ovr));
    end
  end

  task automatic set_cfg(input int s0, input int s1, input int s2, input int s3,
                         input logic [3:0] on, input logic [3:0] el, input logic [3:0] er,
                         input logic [2:0] vl, input logic [2:0] vr, input logic [1:0] rt);
    smp[0] = 16'(s0); smp[1] = 16'(s1); smp[2] = 16'(s2); smp[3] = 16'(s3);
    ch_on = on; enable_l = el; enable_r = er; vol_l = vl; vol_r = vr; psg_ratio = rt;
  endtask

  // Called at a negedge: tick is sampled by the following rising edge.
  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Wait (bounded) for out_valid; n = negedges waited.
  task automatic wait_valid(input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic mix_and_check(input string name, input int exp_l, input int exp_r);
    int n;
    bit ok;
    pulse_tick();
    wait_valid(12, n, ok);
    chk({name, "_timeout"}, int'(ok), 1);
    chk({name, "_latency"}, n + 1, 7);
    chk({name, "_out_l"}, int'(out_l), exp_l);
    chk({name, "_out_r"}, int'(out_r), exp_r);
  endtask

  initial begin
    int  n, vcount;
    bit  ok;
    reset = 1'b1; gb_on = 1'b1; sample_tick = 1'b0;
    set_cfg(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_l", int'(out_l), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);

    set_cfg(10, 5, 0, 0, 4'b0011, 4'b0011, 4'b0000, 3'd7, 3'd3, 2'd2);
    mix_and_check("basic_100", 120, 0);
    set_cfg(10, 5, 0, 0, 4'b0011, 4'b0011, 4'b0000, 3'd7, 3'd3, 2'd0);
    mix_and_check("basic_25", 30, 0);
    set_cfg(0, 0, -16, 0, 4'b0100, 4'b0000, 4'b0100, 3'd5, 3'd0, 2'd1);
    mix_and_check("neg_shift", 0, -8);
    set_cfg(100, 0, -16, 0, 4'b0100, 4'hF, 4'h0, 3'd0, 3'd0, 2'd2);
    mix_and_check("ch_off", -16, 0);
    set_cfg(16000, 16000, 16000, 16000, 4'hF, 4'hF, 4'h0, 3'd7, 3'd0, 2'd2);
`ifdef GBA_PSG_MIX_SATURATE_EN
    mix_and_check("big_sum", 32767, 0);
`else
    mix_and_check("big_sum", -12288, 0);
`endif

    // Volume change after the tick must not affect the mix.
    set_cfg(10, 5, 0, 0, 4'b0011, 4'b0011, 4'b0011, 3'd7, 3'd1, 2'd2);
    pulse_tick();
    @(negedge clk);
    vol_l = 3'd0; vol_r = 3'd7;
    wait_valid(12, n, ok);
    chk("vol_latch_timeout", int'(ok), 1);
    chk("vol_latch_out_l", int'(out_l), 120);
    chk("vol_latch_out_r", int'(out_r), 30);

    // Second tick while busy is dropped; tick in the out_valid cycle is accepted.
    set_cfg(1, 2, 3, 4, 4'hF, 4'hF, 4'h1, 3'd0, 3'd0, 2'd2);
    pulse_tick();
    @(negedge clk);
    pulse_tick();
    wait_valid(12, n, ok);
    chk("overrun_first_timeout", int'(ok), 1);
    chk("overrun_first_latency", n + 3, 7);
    chk("overrun_first_out_l", int'(out_l), 10);
    chk("overrun_flag", int'(overrun), 1);
    chk("overrun_busy_at_valid", int'(busy), 0);
    smp[0] = 16'(7);
    pulse_tick();
    wait_valid(12, n, ok);
    chk("back2back_timeout", int'(ok), 1);
    chk("back2back_latency", n + 1, 7);
    chk("back2back_out_l", int'(out_l), 16);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset mid-mix abandons it.
    set_cfg(10, 5, 0, 0, 4'b0011, 4'b0011, 4'b0011, 3'd7, 3'd7, 2'd2);
    mix_and_check("pre_reset", 120, 120);
    pulse_tick();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("reset_mid_no_valid", vcount, 0);
    chk("reset_mid_out_l", int'(out_l), 0);
    chk("reset_mid_out_r", int'(out_r), 0);
    chk("reset_mid_busy", int'(busy), 0);
    chk("reset_mid_overrun", int'(overrun), 0);

    // Sound master disable mid-mix behaves the same.
    mix_and_check("pre_gb_off", 120, 120);
    pulse_tick();
    @(negedge clk);
    @(negedge clk);
    gb_on = 1'b0;
    @(negedge clk);
    gb_on = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("gb_off_no_valid", vcount, 0);
    chk("gb_off_out_l", int'(out_l), 0);
    chk("gb_off_busy", int'(busy), 0);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      sample_tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) smp[i] = 16'($urandom);
        else smp[i] = 16'(int'($urandom_range(0, 400)) - 200);
      end
      ch_on     = 4'($urandom);
      enable_l  = 4'($urandom);
      enable_r  = 4'($urandom);
      vol_l     = 3'($urandom);
      vol_r     = 3'($urandom);
      psg_ratio = 2'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      gb_on     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    reset = 1'b0;
    gb_on = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
